accum_snapshot_ctrl: RTL and testbench

Sequencer that, on every accumulation-interrupt tick from the time base, copies the six 16-bit correlator results (I/Q early, prompt, late) of every tracking channel that dumped since the previous tick into a snapshot RAM. Firmware then reads a coherent set of results instead of racing the channel dumps register by register. The block sits between the tracking channels' result mux, the time base's accum_enable, and a dual-port snapshot memory whose other port is read over Wishbone.

---
 rtl/accum_snapshot_ctrl.sv | 156 +++++++++++++++
 tb/tb_accum_snapshot_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_snapshot_ctrl.sv
// Snapshot sequencer: on each accumulation tick, copies the six correlator words of
// every channel that dumped since the previous tick into the snapshot RAM.
module accum_snapshot_ctrl #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              accum_enable,
    input  logic [NUM_CH-1:0] ch_dump,
    input  logic [15:0]       ch_data,
    input  logic              snap_ack,
    output logic [2:0]        ch_sel,
    output logic [2:0]        word_sel,
    output logic              mem_we,
    output logic [5:0]        mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [NUM_CH-1:0] snap_mask,
    output logic [NUM_CH-1:0] tear_flags,
    output logic              overrun,
    output logic              snap_int,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_COPY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_WORD = 3'd5;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] job_q, job_d;
    logic [NUM_CH-1:0] job_cap_q, job_cap_d;
    logic [2:0]        ch_sel_q, ch_sel_d;
    logic [2:0]        word_sel_q, word_sel_d;
    logic [NUM_CH-1:0] snap_mask_q, snap_mask_d;
    logic [NUM_CH-1:0] tear_q, tear_d;
    logic              overrun_q, overrun_d;
    logic              snap_int_q, snap_int_d;
    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] tear_set;
    logic              done;

    function automatic logic [2:0] lowest_bit(input logic [NUM_CH-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        sel_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_oh[c] = (ch_sel_q == 3'(c));
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | ch_dump;
        job_d       = job_q;
        job_cap_d   = job_cap_q;
        ch_sel_d    = ch_sel_q;
        word_sel_d  = word_sel_q;
        snap_mask_d = snap_mask_q;
        tear_set    = '0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accum_enable) begin
                    // A dump in the capture cycle belongs to the next tick.
                    job_d     = pending_q;
                    job_cap_d = pending_q;
                    pending_d = ch_dump;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (job_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    ch_sel_d   = lowest_bit(job_q);
                    word_sel_d = 3'd0;
                    state_d    = S_COPY;
                end
            end
            S_COPY: begin
                if (word_sel_q != 3'd0) tear_set = ch_dump & sel_oh;
                if (word_sel_q == LAST_WORD) begin
                    job_d   = job_q & ~sel_oh;
                    state_d = S_SCAN;
                end else begin
                    word_sel_d = word_sel_q + 3'd1;
                end
            end
            S_DONE: begin
                snap_mask_d = job_cap_q;
                done        = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // snap_int is a level held until snap_ack; a flag set in the same
        // cycle as snap_ack survives it, so an ack can never swallow new news.
        snap_int_d = done | (snap_int_q & ~snap_ack);
        overrun_d  = ((state_q != S_IDLE) & accum_enable) | (overrun_q & ~snap_ack);
        tear_d     = tear_set | (tear_q & {NUM_CH{~snap_ack}});
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            job_q       <= '0;
            job_cap_q   <= '0;
            ch_sel_q    <= 3'd0;
            word_sel_q  <= 3'd0;
            snap_mask_q <= '0;
            tear_q      <= '0;
            overrun_q   <= 1'b0;
            snap_int_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            job_q       <= job_d;
            job_cap_q   <= job_cap_d;
            ch_sel_q    <= ch_sel_d;
            word_sel_q  <= word_sel_d;
            snap_mask_q <= snap_mask_d;
            tear_q      <= tear_d;
            overrun_q   <= overrun_d;
            snap_int_q  <= snap_int_d;
        end
    end

    assign mem_we     = (state_q == S_COPY);
    assign mem_addr   = {ch_sel_q, word_sel_q};
    assign mem_wdata  = mem_we ? ch_data : 16'd0;
    assign ch_sel     = ch_sel_q;
    assign word_sel   = word_sel_q;
    assign snap_mask  = snap_mask_q;
    assign tear_flags = tear_q;
    assign overrun    = overrun_q;
    assign snap_int   = snap_int_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_accum_snapshot_ctrl.sv
// Bench for accum_snapshot_ctrl: schedule-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_accum_snapshot_ctrl;

    localparam int NUM_CH = 4;

    logic              clk;
    logic              rstn;
    logic              accum_enable;
    logic [NUM_CH-1:0] ch_dump;
    logic [15:0]       ch_data;
    logic              snap_ack;
    logic [2:0]        ch_sel;
    logic [2:0]        word_sel;
    logic              mem_we;
    logic [5:0]        mem_addr;
    logic [15:0]       mem_wdata;
    logic [NUM_CH-1:0] snap_mask;
    logic [NUM_CH-1:0] tear_flags;
    logic              overrun;
    logic              snap_int;
    logic              busy;
    logic [1:0]        dbg_state;

    accum_snapshot_ctrl #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .rstn(rstn), .accum_enable(accum_enable), .ch_dump(ch_dump),
        .ch_data(ch_data), .snap_ack(snap_ack), .ch_sel(ch_sel), .word_sel(word_sel),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .snap_mask(snap_mask), .tear_flags(tear_flags), .overrun(overrun),
        .snap_int(snap_int), .busy(busy), .dbg_state(dbg_state)
    );

    // Result mux of the tracking channels: one fixed random word per {channel, word}.
    logic [15:0] data_tab [64];
    assign ch_data = data_tab[{ch_sel, word_sel}];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (schedule level) ----------------
    // A tick accepted at edge t with k channels: channel i occupies cycles
    // t+1+7i (scan) and t+2+7i .. t+7+7i (six writes); results show at t+7k+3.
    logic [NUM_CH-1:0] m_pend = '0;
    logic [NUM_CH-1:0] m_job = '0;
    logic [NUM_CH-1:0] m_snap_mask = '0;
    logic [NUM_CH-1:0] m_tear = '0;
    bit                m_overrun = 1'b0;
    bit                m_snap_int = 1'b0;
    bit                m_active = 1'b0;
    int                m_t0 = 0;
    int                m_end = 0;
    int                m_list[$];
    logic [5:0]        exp_q[$];
    logic [5:0]        wr_log[$];
    int                snap_rises = 0;
    bit                prev_si = 1'b0;

    task automatic model_step();
        int e, rel, idx, pos, ch;
        bit in_job, done;
        logic [NUM_CH-1:0] tset;
        e = cyc;
        tset = '0;
        if (!rstn) begin
            m_pend = '0; m_job = '0; m_snap_mask = '0; m_tear = '0;
            m_overrun = 1'b0; m_snap_int = 1'b0; m_active = 1'b0;
            m_list.delete();
            exp_q.delete();
        end else begin
            in_job = m_active && (e >= m_t0 + 1) && (e < m_end);
            done = in_job && (e == m_end - 1);
            if (in_job) begin
                rel = e - m_t0 - 1;
                idx = rel / 7;
                pos = rel % 7;
                if (idx < m_list.size() && pos >= 2) begin
                    ch = m_list[idx];
                    if (ch_dump[ch]) tset[ch] = 1'b1;
                end
            end
            if (done) m_snap_mask = m_job;
            m_snap_int = done ? 1'b1 : (m_snap_int && !snap_ack);
            m_overrun = (in_job && accum_enable) || (m_overrun && !snap_ack);
            m_tear = tset | (snap_ack ? {NUM_CH{1'b0}} : m_tear);
            if (!in_job && accum_enable) begin
                m_job = m_pend;
                m_list.delete();
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_pend[c]) begin
                        m_list.push_back(c);
                        for (int w = 0; w < 6; w++) exp_q.push_back(6'(c * 8 + w));
                    end
                end
                m_t0 = e;
                m_end = e + 7 * m_list.size() + 3;
                m_active = 1'b1;
                m_pend = ch_dump;
            end else begin
                m_pend = m_pend | ch_dump;
            end
        end
        cyc = e + 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard / compare ----------------
    task automatic compare_cycle();
        int rel, idx, pos;
        bit eb, ew;
        logic [5:0] ea;
        eb = m_active && (cyc >= m_t0 + 1) && (cyc < m_end);
        ew = 1'b0;
        if (eb) begin
            rel = cyc - m_t0 - 1;
            idx = rel / 7;
            pos = rel % 7;
            if (idx < m_list.size() && pos >= 1) ew = 1'b1;
        end
        chk("busy", busy, eb);
        chk("mem_we", mem_we, ew);
        if (mem_we === 1'b1) begin
            wr_log.push_back(mem_addr);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual addr=0x%0h required=no write (cycle %0d)", mem_addr, cyc);
            end else begin
                ea = exp_q.pop_front();
                chk("mem_addr", mem_addr, ea);
                chk("mem_wdata", mem_wdata, data_tab[ea]);
            end
        end
        chk("snap_int", snap_int, m_snap_int);
        chk("snap_mask", snap_mask, m_snap_mask);
        chk("tear_flags", tear_flags, m_tear);
        chk("overrun", overrun, m_overrun);
        if (snap_int === 1'b1 && !prev_si) snap_rises++;
        prev_si = (snap_int === 1'b1);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) compare_cycle();
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        accum_enable = 1'b1;
        @(negedge clk);
        accum_enable = 1'b0;
    endtask

    task automatic dump(input logic [NUM_CH-1:0] m);
        ch_dump = m;
        @(negedge clk);
        ch_dump = '0;
    endtask

    task automatic ack();
        snap_ack = 1'b1;
        @(negedge clk);
        snap_ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0;
        logic [5:0] lit_addr [12];
        lit_addr = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13,
                     6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29};
        for (int i = 0; i < 64; i++) data_tab[i] = 16'($urandom);
        rstn = 1'b0; accum_enable = 1'b0; ch_dump = '0; snap_ack = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_snap_int", snap_int, 0);
        chk("reset_mem_addr", mem_addr, 0);

        // Channels 1 and 3 dumped: twelve writes, result in cycle 17 after the tick.
        dump(4'b1010);
        wr_log.delete();
        tick();
        idle(15);
        chk("t1_snap_int_c16", snap_int, 0);
        chk("t1_busy_c16", busy, 1);
        idle(1);
        chk("t1_snap_int_c17", snap_int, 1);
        chk("t1_busy_c17", busy, 0);
        chk("t1_snap_mask", snap_mask, 4'b1010);
        chk("t1_write_count", wr_log.size(), 12);
        for (int i = 0; i < 12 && i < wr_log.size(); i++) chk("t1_write_addr", wr_log[i], lit_addr[i]);
        ack();
        chk("t1_ack_clears", snap_int, 0);
        chk("t1_mask_held", snap_mask, 4'b1010);

        // Empty tick: no writes, result in cycle 3.
        wr_log.delete();
        tick();
        idle(1);
        chk("t2_snap_int_c2", snap_int, 0);
        idle(1);
        chk("t2_snap_int_c3", snap_int, 1);
        chk("t2_snap_mask", snap_mask, 0);
        chk("t2_write_count", wr_log.size(), 0);
        ack();

        // Dump coincident with the tick is carried to the next tick.
        ch_dump = 4'b0100; accum_enable = 1'b1;
        @(negedge clk);
        ch_dump = '0; accum_enable = 1'b0;
        idle(2);
        chk("t3_first_mask", snap_mask, 0);
        chk("t3_first_int", snap_int, 1);
        ack();
        tick();
        idle(9);
        chk("t3_second_int", snap_int, 1);
        chk("t3_second_mask", snap_mask, 4'b0100);
        ack();

        // Dump on channel 0 while its word 3 is being copied.
        dump(4'b0001);
        tick();
        idle(4);
        dump(4'b0001);
        chk("t4_tear", tear_flags, 4'b0001);
        idle(4);
        chk("t4_snap_int", snap_int, 1);
        ack();
        chk("t4_tear_cleared", tear_flags, 0);
        chk("t4_int_cleared", snap_int, 0);
        wr_log.delete();
        tick();
        idle(9);
        chk("t4_repend_mask", snap_mask, 4'b0001);
        chk("t4_repend_writes", wr_log.size(), 6);
        ack();

        // Second tick while busy, then ack coincident with DONE.
        dump(4'b0110);
        r0 = snap_rises;
        tick();
        idle(3);
        tick();
        chk("t5_overrun", overrun, 1);
        idle(11);
        ack();
        chk("t5_int_survives_ack", snap_int, 1);
        chk("t5_mask", snap_mask, 4'b0110);
        idle(20);
        chk("t5_one_snapshot", snap_rises - r0, 1);
        chk("t5_idle", busy, 0);
        ack();

        // Reset in the third copy cycle aborts the snapshot and clears pending.
        dump(4'b0110);
        tick();
        idle(3);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("t6_mem_we", mem_we, 0);
        chk("t6_busy", busy, 0);
        chk("t6_snap_int", snap_int, 0);
        chk("t6_snap_mask", snap_mask, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_mem_wdata", mem_wdata, 0);
        idle(20);
        chk("t6_no_late_int", snap_int, 0);
        dump(4'b1000);
        wr_log.delete();
        tick();
        idle(9);
        chk("t6_fresh_mask", snap_mask, 4'b1000);
        chk("t6_fresh_writes", wr_log.size(), 6);
        ack();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) ch_dump[c] = ($urandom_range(0, 7) == 0);
            accum_enable = ($urandom_range(0, 19) == 0);
            snap_ack = ($urandom_range(0, 11) == 0);
            rstn = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        ch_dump = '0; accum_enable = 1'b0; snap_ack = 1'b0; rstn = 1'b1;
        idle(80);
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
